bcd_lap_timer: RTL and testbench

BCD_LAP_TIMER -- requirements
Module: bcd_lap_timer

---
 rtl/bcd_lap_timer.sv | 159 +++++++++++++++
 tb/tb_bcd_lap_timer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bcd_lap_timer.sv
// Tenths-of-a-second stopwatch / countdown timer with BCD digits {min, sec_tens, sec_ones, tenths},
// lap hold, preset load and expiry on down-count reaching zero.
module bcd_lap_timer #(
  parameter int TICK_DIV = 10_000_000,
  parameter int MIN_MAX  = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        dir,
  input  logic        load,
  input  logic [15:0] preset_bcd,
  input  logic        lap,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        expired,
  output logic        wrap
);

  localparam int              PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]      MIN_TOP = 4'(MIN_MAX);
  localparam logic [15:0]     TOP     = {MIN_TOP, 4'd5, 4'd9, 4'd9};

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t        state, state_d;
  logic [15:0]   count, count_d;
  logic [15:0]   lap_reg, lap_reg_d;
  logic [PW-1:0] ps, ps_d;
  logic          dir_q, dir_d;
  logic          lap_act_d, wrap_d;
  logic          tick, idle_or_paused;

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] hi);
    return (d > hi) ? hi : d;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd9) r[3:0] = c[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (c[7:4] != 4'd9) r[7:4] = c[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (c[11:8] != 4'd5) r[11:8] = c[11:8] + 4'd1;
        else begin
          r[11:8]  = 4'd0;
          r[15:12] = c[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd0) r[3:0] = c[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (c[7:4] != 4'd0) r[7:4] = c[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd9;
        if (c[11:8] != 4'd0) r[11:8] = c[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd5;
          r[15:12] = c[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign tick           = (state == RUN) && (ps == PS_LAST);
  assign idle_or_paused = (state == IDLE) || (state == PAUSED);

  always_comb begin
    state_d   = state;
    count_d   = count;
    ps_d      = ps;
    dir_d     = dir_q;
    lap_reg_d = lap_reg;
    lap_act_d = lap_active;
    wrap_d    = 1'b0;

    // Lap toggling sits beside the state machine; clear below overrides it.
    if (lap) begin
      if (lap_active) lap_act_d = 1'b0;
      else if (state == RUN) begin
        lap_act_d = 1'b1;
        lap_reg_d = count;
      end
    end

    if (clear) begin
      count_d   = 16'h0000;
      lap_act_d = 1'b0;
      state_d   = IDLE;
      ps_d      = '0;
    end else if (load && idle_or_paused) begin
      count_d = {clamp(preset_bcd[15:12], MIN_TOP), clamp(preset_bcd[11:8], 4'd5),
                 clamp(preset_bcd[7:4], 4'd9), clamp(preset_bcd[3:0], 4'd9)};
    end else if (stop) begin
      // stop blocks start in every state, and freezes the prescaler in RUN
      if (state == RUN) state_d = PAUSED;
    end else if (start && idle_or_paused) begin
      if (!(dir && count == 16'h0000)) begin
        dir_d   = dir;
        state_d = RUN;
      end
    end else if (state == RUN) begin
      ps_d = tick ? '0 : ps + PW'(1);
      if (tick) begin
        if (!dir_q) begin
          if (count == TOP) begin
            count_d = 16'h0000;
            wrap_d  = 1'b1;
          end else count_d = bcd_inc(count);
        end else if (count <= 16'h0001) begin
          count_d = 16'h0000;
          state_d = EXPIRED;
        end else count_d = bcd_dec(count);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 16'h0000;
      ps         <= '0;
      dir_q      <= 1'b0;
      lap_reg    <= 16'h0000;
      lap_active <= 1'b0;
      disp_bcd   <= 16'h0000;
      running    <= 1'b0;
      expired    <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      ps         <= ps_d;
      dir_q      <= dir_d;
      lap_reg    <= lap_reg_d;
      lap_active <= lap_act_d;
      disp_bcd   <= lap_active ? lap_reg : count;
      running    <= (state == RUN);
      expired    <= (state == EXPIRED);
      wrap       <= wrap_d;
    end
  end

endmodule

// File: tb/tb_bcd_lap_timer.sv
// Directed bench for bcd_lap_timer with TICK_DIV=4 (one tenth every 4 clocks) and MIN_MAX=9.
module tb_bcd_lap_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, dir = 1'b0, load = 1'b0, lap = 1'b0;
  logic [15:0] preset_bcd = 16'h0000;
  logic [15:0] disp_bcd;
  logic        running, lap_active, expired, wrap;

  int vecs = 0;
  int errs = 0;

  bcd_lap_timer #(.TICK_DIV(4), .MIN_MAX(9)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .dir(dir),
    .load(load), .preset_bcd(preset_bcd), .lap(lap), .disp_bcd(disp_bcd),
    .running(running), .lap_active(lap_active), .expired(expired), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    cyc(2);
    chk("rst_disp", disp_bcd, 16'h0000);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_lap", {15'd0, lap_active}, 16'd0);
    chk("rst_expired", {15'd0, expired}, 16'd0);
    chk("rst_wrap", {15'd0, wrap}, 16'd0);
    reset = 1'b0;

    // up count 1.0 s: ticks land on every 4th edge after the start edge
    start = 1'b1; dir = 1'b0; cyc(1); start = 1'b0;
    cyc(40);
    chk("up_0.9", disp_bcd, 16'h0009);
    cyc(1);
    chk("up_1.0", disp_bcd, 16'h0010);
    chk("up_running", {15'd0, running}, 16'd1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(10);
    chk("stop_running", {15'd0, running}, 16'd0);
    chk("stop_hold", disp_bcd, 16'h0010);

    // rollover at 9:59.9
    clear = 1'b1; cyc(1); clear = 1'b0;
    preset_bcd = 16'h9599; load = 1'b1; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    chk("load_9599", disp_bcd, 16'h9599);
    cyc(3);
    chk("wrap_before", {15'd0, wrap}, 16'd0);
    cyc(1);
    chk("wrap_pulse", {15'd0, wrap}, 16'd1);
    cyc(1);
    chk("wrap_after", {15'd0, wrap}, 16'd0);
    chk("wrap_disp", disp_bcd, 16'h0000);
    chk("wrap_running", {15'd0, running}, 16'd1);

    // down count to expiry
    clear = 1'b1; cyc(1); clear = 1'b0;
    preset_bcd = 16'h0003; load = 1'b1; cyc(1); load = 1'b0;
    start = 1'b1; dir = 1'b1; cyc(1); start = 1'b0; dir = 1'b0;
    cyc(5);
    chk("down_0.2", disp_bcd, 16'h0002);
    cyc(8);
    chk("exp_disp", disp_bcd, 16'h0000);
    chk("exp_flag", {15'd0, expired}, 16'd1);
    chk("exp_running", {15'd0, running}, 16'd0);
    start = 1'b1; cyc(2); start = 1'b0;
    chk("exp_start_ign", {15'd0, running}, 16'd0);
    chk("exp_start_flag", {15'd0, expired}, 16'd1);
    preset_bcd = 16'h0005; load = 1'b1; cyc(1); load = 1'b0; cyc(1);
    chk("exp_load_ign", disp_bcd, 16'h0000);
    clear = 1'b1; cyc(1); clear = 1'b0; cyc(1);
    chk("clr_expired", {15'd0, expired}, 16'd0);
    chk("clr_running", {15'd0, running}, 16'd0);

    // lap hold and release
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(49);
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("lap_set", {15'd0, lap_active}, 16'd1);
    cyc(10);
    chk("lap_hold", disp_bcd, 16'h0012);
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("lap_rel_flag", {15'd0, lap_active}, 16'd0);
    chk("lap_rel_lag", disp_bcd, 16'h0012);
    cyc(1);
    chk("lap_live", disp_bcd, 16'h0015);

    // stop beats start in PAUSED; load clamps digits
    stop = 1'b1; cyc(1); stop = 1'b0; cyc(1);
    chk("pause_running", {15'd0, running}, 16'd0);
    start = 1'b1; stop = 1'b1; cyc(3); start = 1'b0; stop = 1'b0;
    chk("both_running", {15'd0, running}, 16'd0);
    chk("both_hold", disp_bcd, 16'h0015);
    preset_bcd = 16'h7AFF; load = 1'b1; cyc(1); load = 1'b0; cyc(1);
    chk("clamp", disp_bcd, 16'h7599);
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("lap_paused_ign", {15'd0, lap_active}, 16'd0);

    // reset mid-RUN with lap held
    clear = 1'b1; cyc(1); clear = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(101);
    lap = 1'b1; cyc(1); lap = 1'b0;
    cyc(34);
    chk("pre_rst_lap", {15'd0, lap_active}, 16'd1);
    chk("pre_rst_disp", disp_bcd, 16'h0025);
    reset = 1'b1; cyc(1);
    chk("mid_rst_disp", disp_bcd, 16'h0000);
    chk("mid_rst_running", {15'd0, running}, 16'd0);
    chk("mid_rst_lap", {15'd0, lap_active}, 16'd0);
    chk("mid_rst_expired", {15'd0, expired}, 16'd0);
    chk("mid_rst_wrap", {15'd0, wrap}, 16'd0);
    reset = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    chk("restart_zero", disp_bcd, 16'h0000);
    cyc(4);
    chk("restart_0.1", disp_bcd, 16'h0001);
    chk("restart_running", {15'd0, running}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
